// File: rtl/pulse_gen_pkg.sv
// ============================================================================
// pulse_gen_pkg : shared encodings and helpers for the pulse generator
// Rev 1.0
// ============================================================================
`default_nettype none

package pulse_gen_pkg;

    localparam logic [1:0] MODE_RISE = 2'b00;
    localparam logic [1:0] MODE_FALL = 2'b01;
    localparam logic [1:0] MODE_BOTH = 2'b10;
    localparam logic [1:0] MODE_OFF  = 2'b11;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_PULSE = 2'd1;
    localparam state_t ST_HOLD  = 2'd2;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int p = 1; p < value; p = p * 2) begin
            r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pulse_gen_channel.sv
// ============================================================================
// pulse_gen_channel : one channel - synchroniser, edge detect, pulse/repeat FSM
// Rev 1.0
// ============================================================================
`default_nettype none

module pulse_gen_channel
    import pulse_gen_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int PULSE_WIDTH   = 1,
    parameter int REPEAT_DELAY  = 16,
    parameter int REPEAT_PERIOD = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       src,
    input  logic [1:0] mode,
    input  logic       repeat_en,
    output logic       pulse,
    output logic       level
);

    localparam int MAX_RD = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int MAX_V  = (MAX_RD > PULSE_WIDTH) ? MAX_RD : PULSE_WIDTH;
    localparam int CW     = clog2(MAX_V + 1);

    localparam logic [CW-1:0] CNT_MAX = '1;
    localparam logic [CW-1:0] PW_C    = CW'(PULSE_WIDTH);
    localparam logic [CW-1:0] RD_C    = CW'(REPEAT_DELAY);
    localparam logic [CW-1:0] RP_C    = CW'(REPEAT_PERIOD);

    logic          s;
    logic          s_d;
    logic          trigger;
    logic          active_lvl;
    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic [CW-1:0] cnt_inc;
    logic          rep;
    logic          rep_nxt;

    if (SYNC_STAGES == 0) begin : g_no_sync
        assign s = src;
    end else begin : g_sync
        logic [SYNC_STAGES-1:0] sync;

        always_ff @(posedge clk) begin
            if (!reset) begin
                sync <= '0;
            end else begin
                sync[0] <= src;
                for (int i = 1; i < SYNC_STAGES; i++) begin
                    sync[i] <= sync[i-1];
                end
            end
        end

        assign s = sync[SYNC_STAGES-1];
    end

    assign level = s;

    always_comb begin
        trigger    = 1'b0;
        active_lvl = 1'b0;
        case (mode)
            MODE_RISE: begin
                trigger    = s & ~s_d;
                active_lvl = s;
            end
            MODE_FALL: begin
                trigger    = ~s & s_d;
                active_lvl = ~s;
            end
            MODE_BOTH: trigger = s ^ s_d;
            default: ;
        endcase
    end

    // Counter measures cycles since the current pulse start and saturates.
    assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);

    always_ff @(posedge clk) begin
        if (!reset) begin
            s_d   <= 1'b0;
            state <= ST_IDLE;
            cnt   <= '0;
            rep   <= 1'b0;
        end else begin
            s_d   <= s;
            state <= state_nxt;
            cnt   <= cnt_nxt;
            rep   <= rep_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt_inc;
        rep_nxt   = rep;
        case (state)
            ST_IDLE: begin
                cnt_nxt = '0;
                if (trigger) state_nxt = ST_PULSE;
            end
            ST_PULSE: begin
                if (cnt_inc >= PW_C) state_nxt = active_lvl ? ST_HOLD : ST_IDLE;
            end
            ST_HOLD: begin
                if (!active_lvl) begin
                    state_nxt = ST_IDLE;
                end else if (repeat_en && (cnt_inc >= (rep ? RP_C : RD_C))) begin
                    state_nxt = ST_PULSE;
                    cnt_nxt   = '0;
                    rep_nxt   = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (mode == MODE_OFF) state_nxt = ST_IDLE;
        if (state_nxt == ST_IDLE) begin
            cnt_nxt = '0;
            rep_nxt = 1'b0;
        end
    end

    always_comb begin
        pulse = (state == ST_PULSE);
    end

endmodule

`default_nettype wire

// File: rtl/pulse_gen_multi.sv
// ============================================================================
// pulse_gen_multi : NUM_CH independent edge-to-pulse generators
// Rev 1.0
// ============================================================================
`default_nettype none

module pulse_gen_multi
    import pulse_gen_pkg::*;
#(
    parameter int NUM_CH        = 4,
    parameter int SYNC_STAGES   = 2,
    parameter int PULSE_WIDTH   = 1,
    parameter int REPEAT_DELAY  = 16,
    parameter int REPEAT_PERIOD = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_CH-1:0]   src,
    input  logic [2*NUM_CH-1:0] mode,
    input  logic [NUM_CH-1:0]   repeat_en,
    output logic [NUM_CH-1:0]   pulse,
    output logic [NUM_CH-1:0]   level
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        pulse_gen_channel #(
            .SYNC_STAGES  (SYNC_STAGES),
            .PULSE_WIDTH  (PULSE_WIDTH),
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_PERIOD(REPEAT_PERIOD)
        ) u_ch (
            .clk      (clk),
            .reset    (reset),
            .src      (src[i]),
            .mode     (mode[2*i +: 2]),
            .repeat_en(repeat_en[i]),
            .pulse    (pulse[i]),
            .level    (level[i])
        );
    end

endmodule

`default_nettype wire

// File: tb/tb_pulse_gen_multi.sv
// ============================================================================
// tb_pulse_gen_multi : self-checking bench for pulse_gen_multi (three configs)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_pulse_gen_multi;

    localparam int MAXE = 8000;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] src;
    logic [7:0] mode;
    logic [3:0] repeat_en;
    logic [3:0] pulse_a, level_a, pulse_b, level_b, pulse_c, level_c;

    always #5 clk = ~clk;

    pulse_gen_multi dut_a (
        .clk(clk), .reset(reset), .src(src), .mode(mode), .repeat_en(repeat_en),
        .pulse(pulse_a), .level(level_a)
    );

    pulse_gen_multi #(.NUM_CH(4), .SYNC_STAGES(2), .PULSE_WIDTH(3), .REPEAT_DELAY(8),
                      .REPEAT_PERIOD(5)) dut_b (
        .clk(clk), .reset(reset), .src(src), .mode(mode), .repeat_en(repeat_en),
        .pulse(pulse_b), .level(level_b)
    );

    pulse_gen_multi #(.NUM_CH(4), .SYNC_STAGES(0), .PULSE_WIDTH(2), .REPEAT_DELAY(5),
                      .REPEAT_PERIOD(3)) dut_c (
        .clk(clk), .reset(reset), .src(src), .mode(mode), .repeat_en(repeat_en),
        .pulse(pulse_c), .level(level_c)
    );

    int checks = 0;
    int errors = 0;
    int e = 0;
    int base = 0;
    int last_rst = 0;

    logic [3:0] srch [0:MAXE-1];
    bit         mact   [0:2][0:3];
    int         mstart [0:2][0:3];
    int         mnrep  [0:2][0:3];
    logic [3:0] mpulse [0:2];
    logic [3:0] mlevel [0:2];

    typedef struct {
        int         edge_n;
        logic [3:0] src;
        logic [7:0] mode;
        logic [3:0] rep;
        logic [3:0] exp_pulse;
        logic [3:0] exp_level;
    } vec_t;

    vec_t tbl [0:14];

    function automatic int p_ss(input int d);
        return (d == 2) ? 0 : 2;
    endfunction
    function automatic int p_pw(input int d);
        return (d == 0) ? 1 : ((d == 1) ? 3 : 2);
    endfunction
    function automatic int p_rd(input int d);
        return (d == 0) ? 16 : ((d == 1) ? 8 : 5);
    endfunction
    function automatic int p_rp(input int d);
        return (d == 0) ? 4 : ((d == 1) ? 5 : 3);
    endfunction

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at rel edge %0d (abs %0d): got %b expected %b",
                     name, e - base + 1, e + 1, act, exp);
        end
    endtask

    // Reference: a channel is "active" from its pulse start until the level drops;
    // the pulse is high for the first PW cycles after each start.
    task automatic model_edge();
        int ss, pw, age, tgt;
        logic s, sd, trig, act;
        logic [1:0] m;
        srch[e] = src;
        if (!reset) last_rst = e;
        for (int d = 0; d < 3; d++) begin
            ss = p_ss(d);
            pw = p_pw(d);
            for (int ch = 0; ch < 4; ch++) begin
                if (!reset) begin
                    mact[d][ch] = 1'b0;
                end else begin
                    s    = (e - ss > last_rst) ? srch[e-ss][ch] : 1'b0;
                    sd   = (e - ss - 1 > last_rst) ? srch[e-ss-1][ch] : 1'b0;
                    m    = mode[2*ch +: 2];
                    trig = (m == 2'b00 && s && !sd) || (m == 2'b01 && !s && sd) ||
                           (m == 2'b10 && s != sd);
                    act  = (m == 2'b00 && s) || (m == 2'b01 && !s);
                    if (m == 2'b11) begin
                        mact[d][ch] = 1'b0;
                    end else if (!mact[d][ch]) begin
                        if (trig) begin
                            mact[d][ch]   = 1'b1;
                            mstart[d][ch] = e;
                            mnrep[d][ch]  = 0;
                        end
                    end else begin
                        age = e - mstart[d][ch];
                        tgt = (mnrep[d][ch] > 0) ? p_rp(d) : p_rd(d);
                        if (age >= pw) begin
                            if (!act) begin
                                mact[d][ch] = 1'b0;
                            end else if (repeat_en[ch] && age >= tgt) begin
                                mstart[d][ch] = e;
                                mnrep[d][ch]  = mnrep[d][ch] + 1;
                            end
                        end
                    end
                end
                mpulse[d][ch] = mact[d][ch] && (e - mstart[d][ch] < pw);
                if (ss == 0) mlevel[d][ch] = src[ch];
                else mlevel[d][ch] = (e + 1 - ss > last_rst) ? srch[e+1-ss][ch] : 1'b0;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        e++;
        if (e >= MAXE - 2) begin
            $display("FAIL edge_budget: got %0d edges, limit %0d", e, MAXE - 2);
            $fatal(1, "edge budget exhausted");
        end
        model_edge();
        #1;
        check("model_pulse_a", pulse_a, mpulse[0]);
        check("model_level_a", level_a, mlevel[0]);
        check("model_pulse_b", pulse_b, mpulse[1]);
        check("model_level_b", level_b, mlevel[1]);
        check("model_pulse_c", pulse_c, mpulse[2]);
        check("model_level_c", level_c, mlevel[2]);
    endtask

    // After go(m): outputs shown are those sampled at relative edge m, and
    // inputs assigned now are sampled at relative edge m.
    task automatic go(input int m);
        while (e - base < m - 1) step();
    endtask

    task automatic restart();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
        base = e;
    endtask

    initial begin
        reset     = 1'b0;
        src       = '0;
        mode      = '0;
        repeat_en = '0;
        srch[0]   = '0;

        tbl[0]  = '{10, 4'h1, 8'h00, 4'h0, 4'h0, 4'h0};
        tbl[1]  = '{12, 4'h1, 8'h00, 4'h0, 4'h0, 4'h1};
        tbl[2]  = '{13, 4'h1, 8'h00, 4'h0, 4'h1, 4'h1};
        tbl[3]  = '{14, 4'h1, 8'h00, 4'h0, 4'h0, 4'h1};
        tbl[4]  = '{15, 4'h0, 8'h00, 4'h0, 4'h0, 4'h1};
        tbl[5]  = '{16, 4'h0, 8'h00, 4'h0, 4'h0, 4'h1};
        tbl[6]  = '{17, 4'h0, 8'h00, 4'h0, 4'h0, 4'h0};
        tbl[7]  = '{30, 4'hF, 8'h24, 4'h0, 4'h0, 4'h0};
        tbl[8]  = '{32, 4'hF, 8'h24, 4'h0, 4'h0, 4'hF};
        tbl[9]  = '{33, 4'hF, 8'h24, 4'h0, 4'hD, 4'hF};
        tbl[10] = '{34, 4'hF, 8'h24, 4'h0, 4'h0, 4'hF};
        tbl[11] = '{40, 4'h0, 8'h24, 4'h0, 4'h0, 4'hF};
        tbl[12] = '{42, 4'h0, 8'h24, 4'h0, 4'h0, 4'h0};
        tbl[13] = '{43, 4'h0, 8'h24, 4'h0, 4'h6, 4'h0};
        tbl[14] = '{44, 4'h0, 8'h24, 4'h0, 4'h0, 4'h0};

        // Reset state, then single pulse and the all-channel mixed-mode step.
        restart();
        check("reset_pulse_a", pulse_a, 4'h0);
        check("reset_level_a", level_a, 4'h0);
        check("reset_pulse_b", pulse_b, 4'h0);
        check("reset_pulse_c", pulse_c, 4'h0);
        for (int i = 0; i < 15; i++) begin
            go(tbl[i].edge_n);
            check("tbl_pulse", pulse_a, tbl[i].exp_pulse);
            check("tbl_level", level_a, tbl[i].exp_level);
            src       = tbl[i].src;
            mode      = tbl[i].mode;
            repeat_en = tbl[i].rep;
        end

        // Hold-to-repeat on ch0.
        src = '0; mode = 8'h00; repeat_en = 4'h1;
        restart();
        go(10); src[0] = 1'b1;
        for (int m = 11; m <= 46; m++) begin
            go(m);
            check("repeat_pulse0", {3'b0, pulse_a[0]},
                  {3'b0, (m == 13 || m == 29 || m == 33 || m == 37 || m == 41)});
            if (m == 40) src[0] = 1'b0;
        end

        // Both-edge mode, width 3, glitch inside the pulse is ignored.
        src = '0; mode = 8'h08; repeat_en = 4'h0;
        restart();
        go(10); src[1] = 1'b1;
        for (int m = 11; m <= 30; m++) begin
            go(m);
            check("both_pulse1_b", {3'b0, pulse_b[1]},
                  {3'b0, ((m >= 13 && m <= 15) || (m >= 23 && m <= 25))});
            if (m == 20) src[1] = 1'b0;
            if (m == 21) src[1] = 1'b1;
            if (m == 22) src[1] = 1'b0;
        end

        // Disabled channel never pulses; switching to disabled kills a held repeat.
        src = '0; mode = 8'h30; repeat_en = 4'hF;
        restart();
        for (int m = 2; m <= 20; m++) begin
            go(m);
            check("off_pulse2", {3'b0, pulse_a[2]}, 4'h0);
            src[2] = ((m % 3) == 0) ? ~src[2] : src[2];
        end
        src = '0; mode = 8'h00;
        restart();
        go(10); src[2] = 1'b1;
        for (int m = 11; m <= 40; m++) begin
            go(m);
            check("kill_pulse2", {3'b0, pulse_a[2]}, {3'b0, (m == 13)});
            if (m == 20) mode = 8'h30;
        end

        // src high across reset, then a reset in the middle of a pulse.
        src = 4'h1; mode = 8'h00; repeat_en = 4'h0;
        restart();
        for (int m = 2; m <= 12; m++) begin
            go(m);
            check("rst_pulse0_a", {3'b0, pulse_a[0]}, {3'b0, (m == 4 || m == 9)});
            check("rst_pulse0_b", {3'b0, pulse_b[0]},
                  {3'b0, (m == 4 || m == 5 || (m >= 9 && m <= 11))});
            check("rst_pulse0_c", {3'b0, pulse_c[0]},
                  {3'b0, (m == 2 || m == 3 || m == 7 || m == 8)});
            if (m == 5) reset = 1'b0;
            if (m == 6) reset = 1'b1;
        end

        // Randomised traffic against the reference model.
        src = '0; mode = 8'h00; repeat_en = 4'hF;
        restart();
        for (int n = 0; n < 3000; n++) begin
            step();
            for (int ch = 0; ch < 4; ch++) begin
                if ($urandom_range(0, 23) == 0) src[ch] = ~src[ch];
                if ($urandom_range(0, 149) == 0) mode[2*ch +: 2] = 2'($urandom_range(0, 3));
            end
            if ($urandom_range(0, 63) == 0) repeat_en = 4'($urandom_range(0, 15));
            reset = ($urandom_range(0, 399) != 0);
        end
        reset = 1'b1;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
